// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with grant lock, optional hold timer and
// a rotating priority pointer; all outputs are registered.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    localparam bit TIMED = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = TIMED ? HOLD_W'(MAX_HOLD - 1) : '0;

    logic              state, state_nxt;
    logic [2:0]        ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, cnt_nxt;
    logic [2:0]        idx_nxt;
    logic              valid_nxt;
    logic              timeout_nxt;
    logic [7:0]        grant_nxt;

    logic [15:0]       req2;
    logic [7:0]        rot;
    logic [2:0]        off;
    logic [2:0]        win;
    logic              any_req;
    logic              arb;

    // Rotate requests so the pointer position sits at bit 0, then take the lowest set bit.
    always_comb begin
        req2    = {req, req};
        rot     = 8'(req2 >> ptr);
        off     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        win     = ptr + off;
        any_req = |req;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = hold_cnt;
        idx_nxt     = grant_idx;
        valid_nxt   = grant_valid;
        timeout_nxt = 1'b0;
        arb         = 1'b0;

        case (state)
            IDLE: begin
                arb = any_req;
            end
            GRANT: begin
                if (!req[grant_idx]) begin
                    arb = 1'b1;
                end else if (TIMED && hold_cnt == HOLD_LAST) begin
                    arb         = 1'b1;
                    timeout_nxt = 1'b1;
                end else if (TIMED) begin
                    cnt_nxt = HOLD_W'(hold_cnt + 1'b1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Owner's bit is either clear or lowest priority since ptr already moved past it.
        if (arb) begin
            cnt_nxt = '0;
            if (any_req) begin
                idx_nxt   = win;
                valid_nxt = 1'b1;
                ptr_nxt   = win + 3'd1;
                state_nxt = GRANT;
            end else begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        end

        grant_nxt = valid_nxt ? (8'b1 << idx_nxt) : 8'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            hold_cnt    <= '0;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            grant       <= 8'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= cnt_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
            timeout     <= timeout_nxt;
            grant       <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: directed stimulus pushes expected
// outputs, an independent monitor pops and compares every cycle.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    typedef struct {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       t;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    rr_arbiter_8 #(.MAX_HOLD(16), .HOLD_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic r, input logic [7:0] q, input logic [7:0] g,
                        input logic t, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n  = r;
        req    = q;
        e.g    = g;
        e.v    = (g != 8'h00);
        e.t    = t;
        e.idx  = 3'd0;
        for (int i = 0; i < 8; i++) if (g[i]) e.idx = 3'(i);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (grant !== e.g) begin
                    errors++;
                    $display("FAIL %s grant: got %h want %h at %0t", e.name, grant, e.g, $time);
                end
                checks++;
                if (grant_valid !== e.v) begin
                    errors++;
                    $display("FAIL %s grant_valid: got %b want %b at %0t", e.name, grant_valid, e.v, $time);
                end
                checks++;
                if (timeout !== e.t) begin
                    errors++;
                    $display("FAIL %s timeout: got %b want %b at %0t", e.name, timeout, e.t, $time);
                end
                if (e.v) begin
                    checks++;
                    if (grant_idx !== e.idx) begin
                        errors++;
                        $display("FAIL %s grant_idx: got %0d want %0d at %0t", e.name, grant_idx, e.idx, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;

        // Reset with all requests high, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 8'h00, 1'b0, "reset");
        step(1'b1, 8'hFF, 8'h01, 1'b0, "reset_release");

        // Rotation: each owner keeps grant two cycles, then drops its request for one.
        step(1'b1, 8'hFF, 8'h01, 1'b0, "rot_hold0");
        step(1'b1, 8'hFE, 8'h02, 1'b0, "rot_pass0");
        for (int i = 1; i < 8; i++) begin
            logic [7:0] oh;
            logic [7:0] nx;
            oh = 8'h01 << i;
            nx = 8'h01 << ((i + 1) % 8);
            step(1'b1, 8'hFF, oh, 1'b0, "rot_hold");
            step(1'b1, ~oh, nx, 1'b0, "rot_pass");
        end

        // Drop everything: back to idle; then a lone requester for five cycles.
        step(1'b1, 8'h00, 8'h00, 1'b0, "idle");
        step(1'b1, 8'h20, 8'h20, 1'b0, "single_first");
        for (int i = 0; i < 4; i++) step(1'b1, 8'h20, 8'h20, 1'b0, "single_hold");
        step(1'b1, 8'h00, 8'h00, 1'b0, "single_release");
        step(1'b1, 8'h00, 8'h00, 1'b0, "single_idle");

        // Timeout alternation between requesters 1 and 3 (ptr is 6 here, so 1 wins first).
        step(1'b1, 8'h0A, 8'h02, 1'b0, "to_first");
        for (int i = 0; i < 15; i++) step(1'b1, 8'h0A, 8'h02, 1'b0, "to_hold1");
        step(1'b1, 8'h0A, 8'h08, 1'b1, "to_expire1");
        for (int i = 0; i < 15; i++) step(1'b1, 8'h0A, 8'h08, 1'b0, "to_hold3");
        step(1'b1, 8'h0A, 8'h02, 1'b1, "to_expire3");

        // Owner 1 releases; requester 2 alone is re-granted on every expiry.
        step(1'b1, 8'h04, 8'h04, 1'b0, "sole_first");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 15; i++) step(1'b1, 8'h04, 8'h04, 1'b0, "sole_hold");
            step(1'b1, 8'h04, 8'h04, 1'b1, "sole_expire");
        end
        step(1'b1, 8'h04, 8'h04, 1'b0, "sole_after");

        // Mid-grant reset: ptr is 3, so requester 4 takes over on release of 2.
        step(1'b1, 8'h10, 8'h10, 1'b0, "mid_grant");
        step(1'b1, 8'h10, 8'h10, 1'b0, "mid_hold");
        step(1'b0, 8'h10, 8'h00, 1'b0, "mid_reset");
        step(1'b1, 8'hFF, 8'h01, 1'b0, "post_reset");
        step(1'b1, 8'hFF, 8'h01, 1'b0, "post_hold");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter for 8 requesters sharing one resource; owner addressed by a 3-bit index.
- Produces a one-hot grant vector via the team's standard 3-to-8 one-hot decode of a registered grant index.
- Grant locks until owner releases (drops req) or a hold timer expires; a rotating priority pointer guarantees fairness.

Parameters:
- MAX_HOLD, 16, max consecutive cycles one requester may hold grant; 0 = unlimited
- HOLD_W, 5, width of hold counter; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset (sampled on clk rising edge)
- req  input  8  request vector, req[i] high = requester i wants resource; level, held until done
- grant  output  8  one-hot grant, 8'b0 when no owner; grant = decode(grant_idx) gated by grant_valid
- grant_idx  output  3  index of current owner; valid only when grant_valid=1
- grant_valid  output  1  a requester currently owns the resource
- timeout  output  1  one-cycle pulse: current grant forcibly ended by hold timer

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). No async paths.
- Reset (rst_n=0 at edge): grant=8'b0, grant_idx=3'd0, grant_valid=0, timeout=0, ptr=3'd0, hold_cnt=0, state=IDLE. Applies mid-grant too; owner loses grant next cycle with no timeout pulse.
- Internal: state {IDLE, GRANT}, priority pointer ptr[2:0], hold_cnt[HOLD_W-1:0].
- Arbitration function: scan req in order ptr, ptr+1, ..., ptr+7 (mod 8, 7 wraps to 0); first set bit wins. Combinational; result registered.
- IDLE: if req != 0 -> grant_idx<=winner, grant_valid<=1, ptr<=winner+1 (mod 8), hold_cnt<=0, state<=GRANT. Else stay; outputs 0. Latency: req sampled at edge k -> grant visible after edge k (one cycle).
- GRANT, hold: req[grant_idx]=1 and not expired -> grant unchanged, hold_cnt++.
- GRANT, release: req[grant_idx]=0 at edge -> same-edge re-arbitration with updated ptr: if another req set, new grant visible next cycle (no idle gap), hold_cnt<=0; else grant_valid<=0, grant<=0, state<=IDLE.
- GRANT, expiry (MAX_HOLD!=0, req[grant_idx]=1, hold_cnt==MAX_HOLD-1): timeout<=1 for exactly one cycle; re-arbitrate as release. Since ptr already past owner, owner is lowest priority; if it is the only requester it is re-granted (grant bits unchanged, hold_cnt<=0, timeout still pulses).
- Owner holds at most MAX_HOLD consecutive cycles before a timeout pulse.
- Requests from non-owners never disturb an active grant. Newly asserted req competes only at next arbitration point.
- grant is always one-hot or zero; grant_valid=1 iff grant!=0; grant[grant_idx]=grant_valid.
- timeout=0 in every cycle not following an expiry edge.
- MAX_HOLD=0: hold_cnt frozen at 0, timeout never asserts.

Test Plan:
- Reset: drive req=8'hFF with rst_n=0 for 3 cycles -> grant=8'h00, grant_valid=0, timeout=0 throughout; release rst_n -> next cycle grant=8'h01, grant_idx=0.
- Rotation: req=8'hFF, each owner drops req for one cycle after 2 granted cycles then reasserts -> grants in order 8'h01,02,04,...,80,01 (wrap 7->0), no idle cycles between owners.
- Single requester: req=8'h20 only, released after 5 cycles -> grant=8'h20 one cycle after req, held 5 cycles, then grant=8'h00, grant_valid=0, state IDLE.
- Timeout (MAX_HOLD=16): req=8'h0A held constant -> grant=8'h02 for exactly 16 cycles, timeout pulses once, then grant=8'h08 for 16 cycles, timeout, back to 8'h02.
- Timeout, sole requester: req=8'h04 held -> grant stays 8'h04 continuously, timeout pulses every 16 cycles, hold_cnt restarts.
- Mid-grant reset: grant=8'h10 active, rst_n=0 for one edge -> grant=8'h00, grant_valid=0, no timeout; after release with req=8'hFF, first grant is 8'h01 (ptr reset to 0).
